// File: rtl/jzjpcc_control_unit.sv
// rtl/jzjpcc_control_unit.sv - RV32I decode-to-execute control register with load-use stall, flush and illegal-opcode handling
// Optional feature macro: JZJPCC_ILLEGAL_HALT_EN (halt the core on a valid illegal opcode)
module jzjpcc_control_unit #(
  parameter int FLUSH_CYCLES  = 2,
  parameter bit HAZARD_DETECT = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] instruction_decode,
  input  logic        instructionValid_decode,
  input  logic        branchTaken_execute,
  output logic [2:0]  aluOperation_execute,
  output logic        aluMod_execute,
  output logic        rdWriteEnable_execute,
  output logic        memRead_execute,
  output logic        memWrite_execute,
  output logic        branch_execute,
  output logic        jump_execute,
  output logic [4:0]  rdAddr_execute,
  output logic        valid_execute,
  output logic        stall_decode,
  output logic        halted
);

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FLUSH = 2'd1, ST_HALT = 2'd2} state_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_mod;
    logic       rd_we;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [4:0] rd;
    logic       valid;
  } ctrl_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q, ctrl_d, dec_ctrl;
  logic       dec_illegal, uses_rs1, uses_rs2;
  logic       squash, hazard, halt_active, illegal_block;

  // Instruction fields, offset by two because bits [1:0] are not carried.
  logic [4:0] opcode, rd, rs1, rs2;
  logic [2:0] funct3;
  logic       funct7_5;
  assign opcode   = instruction_decode[4:0];
  assign rd       = instruction_decode[9:5];
  assign funct3   = instruction_decode[12:10];
  assign rs1      = instruction_decode[17:13];
  assign rs2      = instruction_decode[22:18];
  assign funct7_5 = instruction_decode[28];

  logic unused_bits;
  assign unused_bits = ^{instruction_decode[29], instruction_decode[27:23]};

  // Decode the opcode into execute control and register-usage flags.
  always_comb begin
    dec_ctrl       = '0;
    dec_ctrl.valid = 1'b1;
    dec_illegal    = 1'b0;
    uses_rs1       = 1'b0;
    uses_rs2       = 1'b0;
    case (opcode)
      OPC_LOAD:   begin dec_ctrl.rd_we = 1'b1; dec_ctrl.mem_read = 1'b1; uses_rs1 = 1'b1; end
      OPC_STORE:  begin dec_ctrl.mem_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_OP_IMM: begin
        dec_ctrl.alu_op  = funct3;
        dec_ctrl.alu_mod = (funct3 == 3'b101) ? funct7_5 : 1'b0;
        dec_ctrl.rd_we   = 1'b1;
        uses_rs1         = 1'b1;
      end
      OPC_OP:     begin
        dec_ctrl.alu_op  = funct3;
        dec_ctrl.alu_mod = funct7_5;
        dec_ctrl.rd_we   = 1'b1;
        uses_rs1         = 1'b1;
        uses_rs2         = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: dec_ctrl.rd_we = 1'b1;
      OPC_BRANCH: begin dec_ctrl.alu_mod = 1'b1; dec_ctrl.branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_JAL:    begin dec_ctrl.jump = 1'b1; dec_ctrl.rd_we = 1'b1; end
      OPC_JALR:   begin dec_ctrl.jump = 1'b1; dec_ctrl.rd_we = 1'b1; uses_rs1 = 1'b1; end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default:    dec_illegal = 1'b1;
    endcase
    // NOPs (fence/system/illegal) carry no destination.
    if (!dec_illegal && opcode != OPC_MISC_MEM && opcode != OPC_SYSTEM)
      dec_ctrl.rd = rd;
    if (rd == 5'd0)
      dec_ctrl.rd_we = 1'b0;
  end

`ifdef JZJPCC_ILLEGAL_HALT_EN
  logic illegal_take;
  assign halt_active   = (state_q == ST_HALT);
  assign illegal_block = dec_illegal;
  assign illegal_take  = (state_q == ST_RUN) && instructionValid_decode && dec_illegal
                         && !branchTaken_execute && !stall_decode;
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
  assign halt_active    = 1'b0;
  assign illegal_block  = 1'b0;
`endif

  assign squash = branchTaken_execute || (state_q == ST_FLUSH);
  assign hazard = ctrl_q.valid && ctrl_q.mem_read && (ctrl_q.rd != 5'd0) && instructionValid_decode
                  && ((uses_rs1 && rs1 == ctrl_q.rd) || (uses_rs2 && rs2 == ctrl_q.rd));
  assign stall_decode = HAZARD_DETECT && hazard && !squash && !halt_active;
  assign halted       = halt_active;

  // State and flush-counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: redirects (re)load the squash counter; illegal opcodes may halt.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN, ST_FLUSH: begin
        if (branchTaken_execute) begin
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end else begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end else if (state_q == ST_FLUSH) begin
          if (cnt_q <= 3'd1) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
`ifdef JZJPCC_ILLEGAL_HALT_EN
        else if (illegal_take) begin
          state_d = ST_HALT;
          cnt_d   = '0;
        end
`endif
      end
`ifdef JZJPCC_ILLEGAL_HALT_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Execute-slot contents: decoded control only when nothing forces a bubble.
  always_comb begin
    ctrl_d = '0;
    if (!halt_active && !squash && !stall_decode && instructionValid_decode && !illegal_block)
      ctrl_d = dec_ctrl;
  end

  // Decode/execute pipeline register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ctrl_q <= '0;
    else       ctrl_q <= ctrl_d;
  end

  assign aluOperation_execute  = ctrl_q.alu_op;
  assign aluMod_execute        = ctrl_q.alu_mod;
  assign rdWriteEnable_execute = ctrl_q.rd_we;
  assign memRead_execute       = ctrl_q.mem_read;
  assign memWrite_execute      = ctrl_q.mem_write;
  assign branch_execute        = ctrl_q.branch;
  assign jump_execute          = ctrl_q.jump;
  assign rdAddr_execute        = ctrl_q.rd;
  assign valid_execute         = ctrl_q.valid;

endmodule

// File: doc/jzjpcc_control_unit.md
# jzjpcc_control_unit

Registered decode-to-execute control unit for the jzjpcc pipelined RV32I core. It decodes every RV32I major opcode into execute-stage control and holds that control in the decode/execute pipeline register. It also detects load-use hazards, squashes wrong-path instructions for a parametrised number of cycles after a taken branch or jump, and flags illegal opcodes. It sits between the decode stage (instruction source) and the execute stage (consumer of all `_execute` outputs).

## Interface
- FLUSH_CYCLES, 2, number of decode-stage instructions squashed per redirect, including the one present in the redirect cycle; legal range 1..7.
- HAZARD_DETECT, 1, 1 enables load-use stall generation; 0 ties stall_decode low.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instruction_decode  in  30  instruction bits [31:2].
- instructionValid_decode  in  1  decode holds a real instruction.
- branchTaken_execute  in  1  execute resolved a taken branch, JAL or JALR this cycle.
- aluOperation_execute  out  3  ALU funct.
- aluMod_execute  out  1  SUB/SRA select.
- rdWriteEnable_execute  out  1  register writeback enable.
- memRead_execute  out  1  load.
- memWrite_execute  out  1  store.
- branch_execute  out  1  conditional branch.
- jump_execute  out  1  JAL/JALR.
- rdAddr_execute  out  5  destination register.
- valid_execute  out  1  execute slot holds a real instruction.
- stall_decode  out  1  combinational; fetch and decode hold this cycle.
- halted  out  1  core halted on an illegal opcode.

## Operation
- Opcode field is instruction_decode[6:2], funct3 is [14:12], funct7[5] is [30], rd is [11:7], rs1 is [19:15], rs2 is [24:20].
- Decode:
  - LOAD: add, rdWE, memRead.
  - STORE: add, memWrite, no rdWE.
  - OP_IMM: funct3; aluMod = funct7[5] only when funct3=101, otherwise 0; rdWE.
  - OP: funct3, aluMod = funct7[5], rdWE.
  - LUI and AUIPC: add, rdWE.
  - BRANCH: aluOp 000, aluMod 1, branch, no rdWE.
  - JAL and JALR: add, jump, rdWE.
  - MISC_MEM and SYSTEM: NOP. All enables are 0, but valid_execute=1.
- rdWriteEnable is forced to 0 when rd=0.
- Illegal is any other opcode. Illegal instructions are handled as NOP unless the Configuration macro is defined.
- Register usage:
  - rs1 is used by OP_IMM, OP, LOAD, STORE, BRANCH and JALR.
  - rs2 is used by OP, STORE and BRANCH.
- Load-use hazard: valid_execute & memRead_execute & rdAddr_execute≠0 & instructionValid_decode & a used rs equal to rdAddr_execute. The hazard asserts stall_decode and loads a bubble into execute.
- Bubble: all `_execute` enables = 0, valid_execute = 0, aluOperation = 000, rdAddr = 0.
- State machine with states RUN, FLUSH and HALT:
  - RUN → FLUSH on branchTaken_execute. The concurrent decode instruction becomes a bubble, and the counter loads FLUSH_CYCLES−1. If FLUSH_CYCLES=1, the state stays RUN.
  - FLUSH: each cycle a bubble is loaded, regardless of instructionValid_decode, and the counter decrements. At counter=1 the next state is RUN.
  - branchTaken_execute during FLUSH reloads the counter.
  - HALT: see Configuration.
- Priority: reset > HALT > branchTaken_execute/FLUSH > hazard stall > normal decode.
- stall_decode is 0 whenever a squash applies.
- instructionValid_decode=0 in RUN loads a bubble.

## Timing
- Reset value of every output is 0, including stall_decode and halted. State is RUN and the counter is 0. Reset takes effect immediately; there is no partial flush afterwards.
- Decode latency: the instruction sampled at edge N appears on the `_execute` outputs after edge N.
- stall_decode is valid in the same cycle as its inputs. The stalled instruction issues on the cycle after the bubble, exactly one stall cycle per load-use.
- Flush: with FLUSH_CYCLES=k, the k consecutive decode slots starting with the redirect cycle become bubbles. Slot k+1 decodes normally.
- Reset asserted mid-FLUSH or in HALT returns to RUN with a cleared counter.

## Configuration
- JZJPCC_ILLEGAL_HALT_EN
  - Defined: a valid illegal opcode decoded in RUN loads a bubble, sets halted=1 and enters HALT the next edge. HALT keeps loading bubbles and ignores branchTaken_execute until reset.
  - Undefined: the HALT state is not built, halted is tied 0, and illegal opcodes decode as NOP with valid_execute=1.

## Test plan
- Reset, then apply `add x3,x1,x2` (0x002081B3) valid → next cycle: aluOp 000, aluMod 0, rdWE 1, rdAddr 3, valid 1.
- `sub x3,x1,x2` (0x402081B3) → aluMod 1. `srai x5,x5,3` (0x4032D293) → aluOp 101, aluMod 1. `sw x2,0(x1)` → memWrite 1, rdWE 0.
- `lw x5,0(x1)` then `add x6,x5,x7` → stall_decode=1 for one cycle, one bubble in execute, then the add issues. The same sequence with `add x6,x0,x7` gives no stall.
- FLUSH_CYCLES=2: branchTaken_execute pulsed while three valid ALU ops stream → first two become bubbles, third issues. A second pulse during FLUSH extends the squash by two more from that cycle.
- Opcode 5'b11111 with the macro defined → halted=1 next cycle, all subsequent outputs are bubbles, and reset clears halted. Without the macro → NOP with valid_execute=1.
- `addi x0,x0,1` → rdWE 0. Reset asserted asynchronously mid-FLUSH → outputs 0 immediately, and normal decode resumes after reset release.
